mem_wb_stage: RTL and testbench

- MEM/WB pipeline register plus write-back logic for the 5-stage MIPS core.
- It is the writer end of the GRF write port. It drives the port's write-enable, destination address, write data and write PC, which the ID-stage register file consumes, including its same-cycle write-through forwarding.
- It captures MEM-stage results, extracts sub-word load data and selects the write-back source.

---
 rtl/mem_wb_stage_pkg.sv | 33 +++
 rtl/mem_wb_stage_if.sv | 32 +++
 rtl/mem_wb_stage_load_ext.sv | 38 +++
 rtl/mem_wb_stage.sv | 87 ++++++++
 tb/tb_mem_wb_stage.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: write-back source codes, load-type codes,
// the stage register layout and the link-address helper.
package mem_wb_stage_pkg;

    // Write-back source select; code 3 is reserved and behaves like WB_ALU.
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC8 = 2'd2;

    // Load types; any other code behaves like LD_W.
    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [1:0]  wsel;
        logic [31:0] alu;
        logic [31:0] memrd;
        logic [2:0]  ldtype;
    } wb_stage_t;

    // jal/jalr link value; wraps modulo 2^32.
    function automatic logic [31:0] link_addr(input logic [31:0] pc);
        return pc + 32'd8;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-side inputs, pipeline control and the GRF write port of the MEM/WB stage.
// master = upstream/consumer side, slave = the stage itself.
interface mem_wb_stage_if;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic        in_we;
    logic [4:0]  in_waddr;
    logic [1:0]  in_wsel;
    logic [31:0] in_alu;
    logic [31:0] in_memrd;
    logic [2:0]  in_ldtype;

    logic        grf_we;
    logic [4:0]  grf_waddr;
    logic [31:0] grf_wdata;
    logic [31:0] grf_wpc;
    logic        wb_valid;

    modport master (
        output stall, flush, in_valid, in_pc, in_we, in_waddr, in_wsel,
               in_alu, in_memrd, in_ldtype,
        input  grf_we, grf_waddr, grf_wdata, grf_wpc, wb_valid
    );

    modport slave (
        input  stall, flush, in_valid, in_pc, in_we, in_waddr, in_wsel,
               in_alu, in_memrd, in_ldtype,
        output grf_we, grf_waddr, grf_wdata, grf_wpc, wb_valid
    );
endinterface

// File: rtl/mem_wb_stage_load_ext.sv
// Combinational sub-word load extraction on little-endian byte lanes.
// Halfwords use lane offset[1]*2; lw ignores the offset entirely.
module load_ext
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  ldtype,
    output logic [31:0] data
);

    logic [7:0]  lanes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = word[gi*8 +: 8];
        end
    endgenerate

    assign sel_byte = lanes[offset];
    assign sel_half = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (ldtype)
            LD_W:    data = word;
            LD_B:    data = {{24{sel_byte[7]}}, sel_byte};
            LD_BU:   data = {24'd0, sel_byte};
            LD_H:    data = {{16{sel_half[15]}}, sel_half};
            LD_HU:   data = {16'd0, sel_half};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back mux driving the GRF write port.
// Optional retired-instruction counter enabled by defining RETIRE_CNT_EN.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_stage_if.slave bus
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0]   retire_cnt
`endif
);

    wb_stage_t   stage_reg;
    wb_stage_t   stage_next;
    logic [31:0] load_data;
    logic [31:0] wb_data;

    // Flush beats stall so a squashed instruction never lingers in a held stage.
    always_comb begin
        stage_next = stage_reg;
        if (bus.flush) begin
            stage_next = '0;
        end else if (!bus.stall) begin
            stage_next.valid  = bus.in_valid;
            stage_next.pc     = bus.in_pc;
            stage_next.we     = bus.in_we;
            stage_next.waddr  = bus.in_waddr;
            stage_next.wsel   = bus.in_wsel;
            stage_next.alu    = bus.in_alu;
            stage_next.memrd  = bus.in_memrd;
            stage_next.ldtype = bus.in_ldtype;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg    <= '0;
            stage_reg.pc <= RESET_PC;
        end else begin
            stage_reg <= stage_next;
        end
    end

    load_ext u_load_ext (
        .word   (stage_reg.memrd),
        .offset (stage_reg.alu[1:0]),
        .ldtype (stage_reg.ldtype),
        .data   (load_data)
    );

    always_comb begin
        wb_data = stage_reg.alu;
        case (stage_reg.wsel)
            WB_ALU:  wb_data = stage_reg.alu;
            WB_MEM:  wb_data = load_data;
            WB_PC8:  wb_data = link_addr(stage_reg.pc);
            default: wb_data = stage_reg.alu;
        endcase
    end

    // $0 is hard-wired to zero, so its write is dropped while the instruction still counts as valid.
    assign bus.grf_we    = stage_reg.valid & stage_reg.we & (stage_reg.waddr != 5'd0);
    assign bus.grf_waddr = stage_reg.waddr;
    assign bus.grf_wdata = stage_reg.valid ? wb_data : 32'd0;
    assign bus.grf_wpc   = stage_reg.pc;
    assign bus.wb_valid  = stage_reg.valid;

`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt_reg;

    // The held instruction leaves on any edge that is not a pure stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_reg <= '0;
        end else if (stage_reg.valid && (!bus.stall || bus.flush)) begin
            retire_cnt_reg <= retire_cnt_reg + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected write-port values are queued when
// stimulus is driven and compared one cycle later.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    typedef struct {
        logic        valid;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] wpc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    mem_wb_stage_if bus ();

`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt;
    mem_wb_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .bus(bus), .retire_cnt(retire_cnt)
    );
`else
    mem_wb_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] lt);
        logic [31:0] sh;
        logic [31:0] hs;
        sh = w >> {off, 3'b000};
        hs = off[1] ? (w >> 16) : w;
        case (lt)
            3'd1:    return {{24{sh[7]}}, sh[7:0]};
            3'd2:    return {24'd0, sh[7:0]};
            3'd3:    return {{16{hs[15]}}, hs[15:0]};
            3'd4:    return {16'd0, hs[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic we,
                         input logic [4:0] wa, input logic [1:0] ws, input logic [31:0] alu,
                         input logic [31:0] memrd, input logic [2:0] lt);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_we     = we;
        bus.in_waddr  = wa;
        bus.in_wsel   = ws;
        bus.in_alu    = alu;
        bus.in_memrd  = memrd;
        bus.in_ldtype = lt;
    endtask

    task automatic push_and_wait(input exp_t e, output exp_t got);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t g;
        logic [70:0] obs;
        drive(1'b1, 32'h0000_3100, 1'b1, 5'd9, WB_ALU, 32'h0000_0055, 32'd0, LD_W);
        e = '{1'b1, 1'b1, 5'd9, 32'h0000_0055, 32'h0000_3100};
        push_and_wait(e, g);
        obs = {bus.wb_valid, bus.grf_we, bus.grf_waddr, bus.grf_wdata, bus.grf_wpc};
        tests_run++;
        if (obs !== {g.valid, g.we, g.waddr, g.wdata, g.wpc}) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset got=%h want=%h", obs, {g.valid, g.we, g.waddr, g.wdata, g.wpc});
        end
        // assert reset between edges with stall and flush both active
        @(negedge clk);
        #2;
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        rst = 1'b1;
        #1;
        obs = {bus.wb_valid, bus.grf_we, bus.grf_waddr, bus.grf_wdata, bus.grf_wpc};
        tests_run++;
        if (obs !== {1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_3000}) begin
            tests_failed++;
            $display("[TB] FAIL async_reset got=%h want=%h", obs, {1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_3000});
        end else
            $display("[TB] async_reset outputs=%h", obs);
`ifdef RETIRE_CNT_EN
        tests_run++;
        if (retire_cnt !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_retire_cnt got=%h want=0", retire_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic test_alu();
        exp_t e;
        exp_t g;
        logic [70:0] obs;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                drive(1'b1, 32'h0000_3004, 1'b1, 5'd5, WB_ALU, 32'h1234_5678, 32'hAAAA_5555, LD_W);
                e = '{1'b1, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_3004};
            end else begin
                drive(1'b1, 32'h0000_3008, 1'b1, 5'd6, 2'd3, 32'hDEAD_BEEF, 32'h1111_2222, LD_B);
                e = '{1'b1, 1'b1, 5'd6, 32'hDEAD_BEEF, 32'h0000_3008};
            end
            push_and_wait(e, g);
            obs = {bus.wb_valid, bus.grf_we, bus.grf_waddr, bus.grf_wdata, bus.grf_wpc};
            tests_run++;
            if (obs !== {g.valid, g.we, g.waddr, g.wdata, g.wpc}) begin
                tests_failed++;
                $display("[TB] FAIL alu_write%0d got=%h want=%h", i, obs, {g.valid, g.we, g.waddr, g.wdata, g.wpc});
            end else
                $display("[TB] alu_write%0d wdata=%h", i, bus.grf_wdata);
        end
    endtask

    task automatic test_loads();
        logic [31:0] memrd_tab [6] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01,
                                       32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
        logic [31:0] alu_tab [6]   = '{32'd2, 32'd2, 32'd3, 32'd1, 32'd2, 32'd3};
        logic [2:0]  lt_tab [6]    = '{LD_B, LD_BU, LD_H, LD_HU, LD_W, 3'd7};
        logic [31:0] want_tab [6]  = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF,
                                       32'h0000_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
        exp_t e;
        exp_t g;
        logic [70:0] obs;
        logic [31:0] w;
        logic [31:0] a;
        logic [2:0]  lt;
        for (int i = 0; i < 22; i++) begin
            if (i < 6) begin
                w = memrd_tab[i];
                a = alu_tab[i];
                lt = lt_tab[i];
                e = '{1'b1, 1'b1, 5'd10, want_tab[i], 32'h0000_3200 + 32'(i * 4)};
            end else begin
                w = $urandom;
                a = $urandom;
                lt = 3'($urandom_range(0, 5));
                e = '{1'b1, 1'b1, 5'd10, ref_load(w, a[1:0], lt), 32'h0000_3200 + 32'(i * 4)};
            end
            drive(1'b1, 32'h0000_3200 + 32'(i * 4), 1'b1, 5'd10, WB_MEM, a, w, lt);
            push_and_wait(e, g);
            obs = {bus.wb_valid, bus.grf_we, bus.grf_waddr, bus.grf_wdata, bus.grf_wpc};
            tests_run++;
            if (obs !== {g.valid, g.we, g.waddr, g.wdata, g.wpc}) begin
                tests_failed++;
                $display("[TB] FAIL load%0d lt=%0d off=%0d got=%h want=%h", i, lt, a[1:0], obs,
                         {g.valid, g.we, g.waddr, g.wdata, g.wpc});
            end else
                $display("[TB] load%0d lt=%0d off=%0d wdata=%h", i, lt, a[1:0], bus.grf_wdata);
        end
    endtask

    task automatic test_jal();
        exp_t e;
        exp_t g;
        logic [70:0] obs;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                drive(1'b1, 32'h0000_3010, 1'b1, 5'd31, WB_PC8, 32'h0000_0040, 32'd0, LD_W);
                e = '{1'b1, 1'b1, 5'd31, 32'h0000_3018, 32'h0000_3010};
            end else begin
                drive(1'b1, 32'hFFFF_FFFC, 1'b1, 5'd31, WB_PC8, 32'h0000_0040, 32'd0, LD_W);
                e = '{1'b1, 1'b1, 5'd31, 32'h0000_0004, 32'hFFFF_FFFC};
            end
            push_and_wait(e, g);
            obs = {bus.wb_valid, bus.grf_we, bus.grf_waddr, bus.grf_wdata, bus.grf_wpc};
            tests_run++;
            if (obs !== {g.valid, g.we, g.waddr, g.wdata, g.wpc}) begin
                tests_failed++;
                $display("[TB] FAIL jal_link%0d got=%h want=%h", i, obs, {g.valid, g.we, g.waddr, g.wdata, g.wpc});
            end else
                $display("[TB] jal_link%0d wdata=%h", i, bus.grf_wdata);
        end
    endtask

    task automatic test_zero_and_invalid();
        exp_t e;
        exp_t g;
        logic [70:0] obs;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                drive(1'b1, 32'h0000_3020, 1'b1, 5'd0, WB_ALU, 32'h0000_0777, 32'd0, LD_W);
                e = '{1'b1, 1'b0, 5'd0, 32'h0000_0777, 32'h0000_3020};
            end else begin
                drive(1'b0, 32'h0000_3024, 1'b1, 5'd12, WB_ALU, 32'h0000_0999, 32'd0, LD_W);
                e = '{1'b0, 1'b0, 5'd12, 32'd0, 32'h0000_3024};
            end
            push_and_wait(e, g);
            obs = {bus.wb_valid, bus.grf_we, bus.grf_waddr, bus.grf_wdata, bus.grf_wpc};
            tests_run++;
            if (obs !== {g.valid, g.we, g.waddr, g.wdata, g.wpc}) begin
                tests_failed++;
                $display("[TB] FAIL zero_guard%0d got=%h want=%h", i, obs, {g.valid, g.we, g.waddr, g.wdata, g.wpc});
            end else
                $display("[TB] zero_guard%0d we=%b valid=%b", i, bus.grf_we, bus.wb_valid);
        end
    endtask

    task automatic test_stall_flush();
        exp_t e;
        exp_t g;
        logic [70:0] obs;
        logic [33:0] obs_b;
        int exp_cnt;
        // start from an empty stage so the retire count is known
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        drive(1'b1, 32'h0000_3040, 1'b1, 5'd7, WB_ALU, 32'hCAFE_0001, 32'd0, LD_W);
        e = '{1'b1, 1'b1, 5'd7, 32'hCAFE_0001, 32'h0000_3040};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                drive(1'b1, 32'h0000_3100 + 32'(i), 1'b1, 5'(20 + i), WB_PC8, 32'h5555_0000 + 32'(i),
                      32'd0, LD_W);
                bus.stall = 1'b1;
            end
            push_and_wait(e, g);
            obs = {bus.wb_valid, bus.grf_we, bus.grf_waddr, bus.grf_wdata, bus.grf_wpc};
            tests_run++;
            if (obs !== {g.valid, g.we, g.waddr, g.wdata, g.wpc}) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold%0d got=%h want=%h", i, obs, {g.valid, g.we, g.waddr, g.wdata, g.wpc});
            end else
                $display("[TB] stall_hold%0d wdata=%h", i, bus.grf_wdata);
        end
        drive(1'b1, 32'h0000_3200, 1'b1, 5'd25, WB_ALU, 32'h0BAD_0BAD, 32'd0, LD_W);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        exp_cnt++;
        e = '{1'b0, 1'b0, 5'd0, 32'd0, 32'd0};
        push_and_wait(e, g);
        obs_b = {bus.wb_valid, bus.grf_we, bus.grf_wdata};
        tests_run++;
        if (obs_b !== {g.valid, g.we, g.wdata}) begin
            tests_failed++;
            $display("[TB] FAIL stall_flush_bubble got=%h want=%h", obs_b, {g.valid, g.we, g.wdata});
        end else
            $display("[TB] stall_flush_bubble valid=%b we=%b", bus.wb_valid, bus.grf_we);
`ifdef RETIRE_CNT_EN
        tests_run++;
        if (retire_cnt !== 32'(exp_cnt)) begin
            tests_failed++;
            $display("[TB] FAIL retire_after_flush got=%0d want=%0d", retire_cnt, exp_cnt);
        end
`endif
        drive(1'b0, 32'd0, 1'b0, 5'd0, WB_ALU, 32'd0, 32'd0, LD_W);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        e = '{1'b0, 1'b0, 5'd0, 32'd0, 32'd0};
        push_and_wait(e, g);
        obs_b = {bus.wb_valid, bus.grf_we, bus.grf_wdata};
        tests_run++;
        if (obs_b !== {g.valid, g.we, g.wdata}) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_flush got=%h want=%h", obs_b, {g.valid, g.we, g.wdata});
        end else
            $display("[TB] idle_after_flush valid=%b", bus.wb_valid);
`ifdef RETIRE_CNT_EN
        tests_run++;
        if (retire_cnt !== 32'(exp_cnt)) begin
            tests_failed++;
            $display("[TB] FAIL retire_idle got=%0d want=%0d", retire_cnt, exp_cnt);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = 32'd0;
        bus.in_we     = 1'b0;
        bus.in_waddr  = 5'd0;
        bus.in_wsel   = WB_ALU;
        bus.in_alu    = 32'd0;
        bus.in_memrd  = 32'd0;
        bus.in_ldtype = LD_W;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_alu();
        test_loads();
        test_jal();
        test_zero_and_invalid();
        test_stall_flush();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
